// File: rtl/address_fixup_ctrl_if.sv
// Bus between decode/timing logic and the address fixup sequencer.
// The master drives the request and carry inputs; the slave (sequencer) drives the ALU high-byte controls.
interface address_fixup_ctrl_if;
  logic       enableFFs;
  logic       start;
  logic [1:0] mode;
  logic       offsetSign;
  logic       freeCarry;
  logic       clearCount;
  logic       lowAddEn;
  logic       busy;
  logic       fixupCycle;
  logic       pchInc;
  logic       pchDec;
  logic       done;
  logic [7:0] fixupCount;

  modport master (
    output enableFFs, start, mode, offsetSign, freeCarry, clearCount,
    input  lowAddEn, busy, fixupCycle, pchInc, pchDec, done, fixupCount
  );

  modport slave (
    input  enableFFs, start, mode, offsetSign, freeCarry, clearCount,
    output lowAddEn, busy, fixupCycle, pchInc, pchDec, done, fixupCount
  );
endinterface

// File: rtl/address_fixup_ctrl.sv
// Low/high address byte fixup sequencer for indexed absolute and relative-branch addressing.
// Enables the free-carry FF during the low-byte add, then optionally inserts one PCH/ADH inc/dec cycle.
module address_fixup_ctrl (
  input  logic                       clk,
  input  logic                       nrst,
  address_fixup_ctrl_if.slave        bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW   = 3'd1,
    EVAL  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_IDX_RD  = 2'b00;
  localparam logic [1:0] MODE_IDX_WR  = 2'b01;
  localparam logic [1:0] MODE_BRANCH  = 2'b10;

  state_t     state_reg, state_next;
  logic [1:0] mode_reg, mode_next;
  logic       sign_reg, sign_next;
  logic       inc_reg, inc_next;
  logic       dec_reg, dec_next;
  logic [7:0] count_reg;

  logic       need;
  logic       inc_eval;
  logic       dec_eval;

  // Carry decision from the latched mode; only meaningful while in EVAL.
  always_comb begin
    need     = 1'b0;
    inc_eval = 1'b0;
    dec_eval = 1'b0;
    case (mode_reg)
      MODE_IDX_RD: begin
        need     = bus.freeCarry;
        inc_eval = bus.freeCarry;
      end
      MODE_IDX_WR: begin
        need     = 1'b1;
        inc_eval = bus.freeCarry;
      end
      MODE_BRANCH: begin
        need     = bus.freeCarry ^ sign_reg;
        inc_eval = bus.freeCarry & ~sign_reg;
        dec_eval = ~bus.freeCarry & sign_reg;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    sign_next  = sign_reg;
    inc_next   = inc_reg;
    dec_next   = dec_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = LOW;
          mode_next  = bus.mode;
          sign_next  = bus.offsetSign;
        end
      end
      LOW:  state_next = EVAL;
      EVAL: begin
        inc_next   = inc_eval;
        dec_next   = dec_eval;
        state_next = need ? FIXUP : DONE;
      end
      FIXUP: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= IDLE;
      mode_reg  <= 2'b00;
      sign_reg  <= 1'b0;
      inc_reg   <= 1'b0;
      dec_reg   <= 1'b0;
    end else if (bus.enableFFs) begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      sign_reg  <= sign_next;
      inc_reg   <= inc_next;
      dec_reg   <= dec_next;
    end
  end

  // Clear wins over a same-edge increment and ignores the freeze.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_reg <= 8'd0;
    end else if (bus.clearCount) begin
      count_reg <= 8'd0;
    end else if (bus.enableFFs && state_reg == EVAL && need) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign bus.lowAddEn   = (state_reg == LOW);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.fixupCycle = (state_reg == FIXUP);
  assign bus.pchInc     = (state_reg == FIXUP) & inc_reg;
  assign bus.pchDec     = (state_reg == FIXUP) & dec_reg;
  assign bus.done       = (state_reg == DONE);
  assign bus.fixupCount = count_reg;

endmodule

// File: tb/tb_address_fixup_ctrl.sv
// Directed self-checking bench for address_fixup_ctrl: drives and samples on the falling edge.
module tb_address_fixup_ctrl;

  logic clk;
  logic nrst;
  int   tests_run;
  int   tests_failed;
  logic [7:0] exp_count;

  address_fixup_ctrl_if bus ();

  address_fixup_ctrl dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":lowAddEn"},   32'(bus.lowAddEn),   32'd0);
    check({tag, ":busy"},       32'(bus.busy),       32'd0);
    check({tag, ":fixupCycle"}, 32'(bus.fixupCycle), 32'd0);
    check({tag, ":pchInc"},     32'(bus.pchInc),     32'd0);
    check({tag, ":pchDec"},     32'(bus.pchDec),     32'd0);
    check({tag, ":done"},       32'(bus.done),       32'd0);
    check({tag, ":count"},      32'(bus.fixupCount), 32'd0);
  endtask

  // Full checked sequence; start accepted at the edge following the first negedge.
  task automatic run_seq(input string name, input logic [1:0] m, input logic s, input logic c,
                         input logic fix, input logic inc, input logic dec);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.offsetSign = s;
    @(negedge clk);
    bus.start = 1'b0;
    check({name, ":low_en"},   32'(bus.lowAddEn), 32'd1);
    check({name, ":low_busy"}, 32'(bus.busy),     32'd1);
    @(negedge clk);
    check({name, ":eval_en"},  32'(bus.lowAddEn), 32'd0);
    bus.freeCarry = c;
    @(negedge clk);
    bus.freeCarry = 1'b0;
    if (fix) begin
      exp_count = exp_count + 8'd1;
      check({name, ":fix"},      32'(bus.fixupCycle), 32'd1);
      check({name, ":inc"},      32'(bus.pchInc),     32'(inc));
      check({name, ":dec"},      32'(bus.pchDec),     32'(dec));
      check({name, ":fix_done"}, 32'(bus.done),       32'd0);
      @(negedge clk);
    end else begin
      check({name, ":nofix"}, 32'(bus.fixupCycle), 32'd0);
    end
    check({name, ":done"},  32'(bus.done),       32'd1);
    check({name, ":count"}, 32'(bus.fixupCount), 32'(exp_count));
    @(negedge clk);
    check({name, ":idle_busy"}, 32'(bus.busy), 32'd0);
    check({name, ":idle_done"}, 32'(bus.done), 32'd0);
    $display("[TB] seq %s mode=%0d sign=%0d carry=%0d fixup=%0d count=%0d",
             name, m, s, c, fix, bus.fixupCount);
  endtask

  // Unchecked INDEXED_WRITE sequence (always one fixup) for counter stepping.
  task automatic quick_fix_seq();
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b01;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    exp_count = exp_count + 8'd1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_count    = 8'd0;
    nrst = 1'b0;
    bus.enableFFs  = 1'b1;
    bus.start      = 1'b0;
    bus.mode       = 2'b00;
    bus.offsetSign = 1'b0;
    bus.freeCarry  = 1'b0;
    bus.clearCount = 1'b0;

    // Reset with random inputs toggling
    repeat (4) begin
      @(negedge clk);
      bus.start      = 1'($urandom_range(0, 1));
      bus.mode       = 2'($urandom_range(0, 3));
      bus.offsetSign = 1'($urandom_range(0, 1));
      bus.freeCarry  = 1'($urandom_range(0, 1));
    end
    #1;
    check_all_zero("reset");
    $display("[TB] reset held, outputs checked");
    @(negedge clk);
    bus.start = 1'b0; bus.mode = 2'b00; bus.offsetSign = 1'b0;
    bus.freeCarry = 1'b0; bus.enableFFs = 1'b1;
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("post_reset");
    $display("[TB] reset released, idle checked");

    run_seq("rd_c0",  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_seq("rd_c1",  2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_seq("br_neg", 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    run_seq("br_pos", 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_seq("br_nop", 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_seq("wr_c0",  2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_seq("wr_c1",  2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_seq("rsv",    2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Freeze two cycles in LOW; held start while busy must not retrigger
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b00;
    @(negedge clk);
    bus.enableFFs = 1'b0;
    check("frz:low0", 32'(bus.lowAddEn), 32'd1);
    @(negedge clk);
    check("frz:low1", 32'(bus.lowAddEn), 32'd1);
    @(negedge clk);
    check("frz:low2", 32'(bus.lowAddEn), 32'd1);
    bus.enableFFs = 1'b1;
    @(negedge clk);
    check("frz:eval", 32'(bus.lowAddEn), 32'd0);
    check("frz:eval_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("frz:done", 32'(bus.done), 32'd1);
    bus.enableFFs = 1'b0;
    @(negedge clk);
    check("frz:done_hold", 32'(bus.done), 32'd1);
    bus.enableFFs = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("frz:idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("frz:no_retrig", 32'(bus.busy), 32'd0);
    $display("[TB] seq freeze_low/start_while_busy checked");

    // Reset pulse during FIXUP aborts with no done
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b01;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_count = exp_count + 8'd1;
    check("abort:fix", 32'(bus.fixupCycle), 32'd1);
    nrst = 1'b0;
    #1;
    check("abort:busy", 32'(bus.busy), 32'd0);
    exp_count = 8'd0;
    check("abort:count", 32'(bus.fixupCount), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    check("abort:no_done", 32'(bus.done), 32'd0);
    check("abort:idle", 32'(bus.busy), 32'd0);
    $display("[TB] seq reset_in_fixup checked");

    // Counter wrap
    repeat (255) quick_fix_seq();
    @(negedge clk);
    check("cnt:255", 32'(bus.fixupCount), 32'd255);
    quick_fix_seq();
    @(negedge clk);
    check("cnt:wrap", 32'(bus.fixupCount), 32'd0);
    $display("[TB] seq counter_wrap count=%0d", bus.fixupCount);

    // Clear coincident with EVAL->FIXUP increment
    quick_fix_seq();
    @(negedge clk);
    check("clr:pre", 32'(bus.fixupCount), 32'd1);
    bus.start = 1'b1; bus.mode = 2'b01;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.clearCount = 1'b1;
    @(negedge clk);
    bus.clearCount = 1'b0;
    check("clr:fix", 32'(bus.fixupCycle), 32'd1);
    check("clr:count", 32'(bus.fixupCount), 32'd0);
    repeat (2) @(negedge clk);
    $display("[TB] seq clear_vs_increment count=%0d", bus.fixupCount);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
